// File: rtl/ssit_mp_pkg.sv
// Shared widths, index/SSID types and sweep state encoding for the store-set identifier table.
// The periodic sweep is compiled in only when SSIT_PERIODIC_CLEAR_EN is defined.
package ssit_mp_pkg;

  localparam int SSIT_IDX_W  = 12;
  localparam int SSIT_SSID_W = 7;

  typedef logic [SSIT_IDX_W-1:0]  idx_t;
  typedef logic [SSIT_SSID_W-1:0] ssid_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/ssit_ssid_alloc.sv
// Wrapping store-set ID allocator: requesting ports receive consecutive IDs in ascending
// port order and the counter advances by the number of IDs handed out.
module ssit_ssid_alloc
  import ssit_mp_pkg::*;
#(
  parameter int SSID_W   = SSIT_SSID_W,
  parameter int NUM_VIOL = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_VIOL-1:0]        req,
  output logic [NUM_VIOL*SSID_W-1:0] ssid
);

  logic [SSID_W-1:0] cnt;
  logic [SSID_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    ssid    = '0;
    for (int p = 0; p < NUM_VIOL; p++) begin
      ssid[p*SSID_W +: SSID_W] = cnt_nxt;
      if (req[p]) cnt_nxt = cnt_nxt + SSID_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ssit_mp.sv
// Multi-port store set identifier table: registered lookups, violation training with
// store-set merge rules, and an optional periodic invalidation sweep (SSIT_PERIODIC_CLEAR_EN).
module ssit_mp
  import ssit_mp_pkg::*;
#(
  parameter int IDX_W      = SSIT_IDX_W,
  parameter int SSID_W     = SSIT_SSID_W,
  parameter int NUM_RD     = 4,
  parameter int NUM_VIOL   = 2,
  parameter int CLR_PERIOD = 65536
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          rd_vld_i,
  input  logic [NUM_RD*IDX_W-1:0]    rd_idx_i,
  output logic [NUM_RD*SSID_W-1:0]   rd_ssid_o,
  output logic [NUM_RD-1:0]          rd_ssid_vld_o,
  input  logic [NUM_VIOL-1:0]        viol_vld_i,
  input  logic [NUM_VIOL*IDX_W-1:0]  viol_ld_idx_i,
  input  logic [NUM_VIOL*IDX_W-1:0]  viol_st_idx_i,
  output logic                       clr_busy_o
);

  localparam int DEPTH = 2**IDX_W;

  function automatic logic [SSID_W-1:0] ssid_min(input logic [SSID_W-1:0] a,
                                                 input logic [SSID_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [DEPTH-1:0]            valid;
  logic [SSID_W-1:0]           ssid_mem [DEPTH];

  logic [IDX_W-1:0]            ld_idx   [NUM_VIOL];
  logic [IDX_W-1:0]            st_idx   [NUM_VIOL];
  logic [NUM_VIOL-1:0]         need_alloc;
  logic [NUM_VIOL-1:0]         wr_ld;
  logic [NUM_VIOL-1:0]         wr_st;
  logic [SSID_W-1:0]           wr_ssid  [NUM_VIOL];
  logic [NUM_VIOL*SSID_W-1:0]  alloc_ssid;

  logic                        sweep_en;
  logic [IDX_W-1:0]            sweep_ptr;

  // Training decode: a port needs a fresh SSID only when neither entry is valid
  always_comb begin
    need_alloc = '0;
    for (int p = 0; p < NUM_VIOL; p++) begin
      ld_idx[p]     = viol_ld_idx_i[p*IDX_W +: IDX_W];
      st_idx[p]     = viol_st_idx_i[p*IDX_W +: IDX_W];
      need_alloc[p] = viol_vld_i[p] & ~valid[ld_idx[p]] & ~valid[st_idx[p]];
    end
  end

  ssit_ssid_alloc #(
    .SSID_W   (SSID_W),
    .NUM_VIOL (NUM_VIOL)
  ) u_alloc (
    .clock (clock),
    .reset (reset),
    .req   (need_alloc),
    .ssid  (alloc_ssid)
  );

  // Merge rules evaluated against pre-edge table state; L == S falls out naturally
  always_comb begin : merge_blk
    logic              lv;
    logic              sv;
    logic [SSID_W-1:0] ls;
    logic [SSID_W-1:0] ss;
    wr_ld = '0;
    wr_st = '0;
    for (int p = 0; p < NUM_VIOL; p++) begin
      lv         = valid[ld_idx[p]];
      sv         = valid[st_idx[p]];
      ls         = ssid_mem[ld_idx[p]];
      ss         = ssid_mem[st_idx[p]];
      wr_ssid[p] = alloc_ssid[p*SSID_W +: SSID_W];
      if (viol_vld_i[p]) begin
        case ({lv, sv})
          2'b00: begin
            wr_ld[p] = 1'b1;
            wr_st[p] = 1'b1;
          end
          2'b10: begin
            wr_st[p]   = 1'b1;
            wr_ssid[p] = ls;
          end
          2'b01: begin
            wr_ld[p]   = 1'b1;
            wr_ssid[p] = ss;
          end
          2'b11: begin
            if (ls != ss) begin
              wr_ld[p]   = 1'b1;
              wr_st[p]   = 1'b1;
              wr_ssid[p] = ssid_min(ls, ss);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // SSID storage; later (higher-numbered) ports override earlier ones on the same index
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_VIOL; p++) begin
      if (wr_ld[p]) ssid_mem[ld_idx[p]] <= wr_ssid[p];
      if (wr_st[p]) ssid_mem[st_idx[p]] <= wr_ssid[p];
    end
  end

  // Valid bits: sweep clear first so a same-cycle training write of the swept entry wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (sweep_en) valid[sweep_ptr] <= 1'b0;
      for (int p = 0; p < NUM_VIOL; p++) begin
        if (wr_ld[p]) valid[ld_idx[p]] <= 1'b1;
        if (wr_st[p]) valid[st_idx[p]] <= 1'b1;
      end
    end
  end

  // Lookup stage: results reflect table contents before this edge's training writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ssid_o     <= '0;
      rd_ssid_vld_o <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_ssid_vld_o[p] <= rd_vld_i[p] & valid[rd_idx_i[p*IDX_W +: IDX_W]];
        if (rd_vld_i[p]) begin
          rd_ssid_o[p*SSID_W +: SSID_W] <= ssid_mem[rd_idx_i[p*IDX_W +: IDX_W]];
        end
      end
    end
  end

`ifdef SSIT_PERIODIC_CLEAR_EN
  localparam int CNT_W = $clog2(CLR_PERIOD);

  sweep_state_e      state;
  logic [CNT_W-1:0]  period_cnt;

  // Period counter keeps running through CLEAR so sweep starts stay CLR_PERIOD apart
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      period_cnt <= '0;
      sweep_ptr  <= '0;
    end else if (state == IDLE && period_cnt == CNT_W'(CLR_PERIOD - 1)) begin
      state      <= CLEAR;
      sweep_ptr  <= '0;
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
      if (state == CLEAR) begin
        sweep_ptr <= sweep_ptr + IDX_W'(1);
        if (sweep_ptr == IDX_W'(DEPTH - 1)) state <= IDLE;
      end
    end
  end

  assign sweep_en   = (state == CLEAR);
  assign clr_busy_o = sweep_en;
`else
  logic unused_clr_period;

  assign sweep_en          = 1'b0;
  assign sweep_ptr         = '0;
  assign clr_busy_o        = 1'b0;
  assign unused_clr_period = (CLR_PERIOD != 0);
`endif

endmodule
